// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg : shared constants for the I2S audio receiver
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int I2S_DATA_WIDTH  = 16;
  localparam int I2S_SYNC_STAGES = 2;
  localparam int I2S_CNT_W       = 5;

endpackage : i2s_pkg

`default_nettype wire

// File: rtl/i2s_sync_ff.sv
// ============================================================================
// i2s_sync_ff : 1-bit multi-stage flop synchronizer, sync active-low reset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module i2s_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule : i2s_sync_ff

`default_nettype wire

// File: rtl/i2s_audio_receiver.sv
// ============================================================================
// i2s_audio_receiver : I2S deserializer presenting words in the sys_clk domain
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module i2s_audio_receiver
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  i2s_bclk,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  channel_id
);

  logic bclk_s;
  logic ws_s;
  logic sd_s;

  i2s_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (i2s_bclk),
    .q    (bclk_s)
  );

  i2s_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ws (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (i2s_ws),
    .q    (ws_s)
  );

  i2s_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (i2s_sd),
    .q    (sd_s)
  );

  logic                  bclk_prev_q, bclk_prev_d;
  logic                  armed_q,     armed_d;
  logic                  ws_prev_q,   ws_prev_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [I2S_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] sample_q,    sample_d;
  logic                  valid_q,     valid_d;
  logic                  chan_q,      chan_d;

  logic bclk_rise;
  assign bclk_rise = bclk_s & ~bclk_prev_q;

  always_comb begin
    bclk_prev_d = bclk_s;
    armed_d     = armed_q;
    ws_prev_d   = ws_prev_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    sample_d    = sample_q;
    chan_d      = chan_q;
    valid_d     = 1'b0;

    if (bclk_rise) begin
      if (!armed_q || (ws_s == ws_prev_q)) begin
        // First edge after reset only latches the channel; it still carries data
        armed_d   = 1'b1;
        ws_prev_d = ws_s;
        shift_d   = {shift_q[DATA_WIDTH-2:0], sd_s};
        bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + 1'b1;
      end else begin
        // Word boundary: this edge's sd is the one-bit-delay slot, dropped
        if (bit_cnt_q != '0) begin
          sample_d = shift_q;
          chan_d   = ws_prev_q;
          valid_d  = 1'b1;
        end
        shift_d   = '0;
        bit_cnt_d = '0;
        ws_prev_d = ws_s;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      ws_prev_q   <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      chan_q      <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_prev_d;
      armed_q     <= armed_d;
      ws_prev_q   <= ws_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      chan_q      <= chan_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign channel_id   = chan_q;

endmodule : i2s_audio_receiver

`default_nettype wire

// File: tb/tb_i2s_audio_receiver.sv
// ============================================================================
// tb_i2s_audio_receiver : directed self-checking bench for i2s_audio_receiver
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2s_audio_receiver;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        i2s_bclk = 1'b0;
  logic        i2s_ws = 1'b0;
  logic        i2s_sd = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        channel_id;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [15:0] cap_data [0:15];
  logic        cap_ch   [0:15];
  longint      cap_lat  [0:15];
  int          cap_cnt = 0;
  int          run     = 0;
  int          max_run = 0;
  longint      last_rise = 0;

  i2s_audio_receiver #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .i2s_bclk    (i2s_bclk),
    .i2s_ws      (i2s_ws),
    .i2s_sd      (i2s_sd),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .channel_id  (channel_id)
  );

  always #10 sys_clk = ~sys_clk;

  // Pulse capture, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (sample_valid) begin
      run = run + 1;
      if (run > max_run) max_run = run;
      if (run == 1) begin
        if (cap_cnt < 16) begin
          cap_data[cap_cnt] = sample_out;
          cap_ch[cap_cnt]   = channel_id;
          cap_lat[cap_cnt]  = $time - last_rise;
        end
        cap_cnt = cap_cnt + 1;
      end
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bclk_cycle(input logic ws, input logic sd);
    i2s_bclk = 1'b0;
    #50;
    i2s_ws = ws;
    i2s_sd = sd;
    #926;
    i2s_bclk  = 1'b1;
    last_rise = $time;
    #977;
  endtask

  task automatic send_word(input logic ch, input logic [31:0] data, input int nbits);
    bclk_cycle(ch, 1'b0);
    for (int i = nbits - 1; i >= 0; i--) bclk_cycle(ch, data[i]);
  endtask

  // After a word: the boundary at its start must have produced emission idx
  task automatic chk_emit(input string tag, input int idx, input logic [15:0] d, input logic ch);
    chk({tag, "_count"}, cap_cnt, idx + 1);
    chk({tag, "_data"}, {16'h0, cap_data[idx]}, {16'h0, d});
    chk({tag, "_chan"}, {31'h0, cap_ch[idx]}, {31'h0, ch});
    chk({tag, "_hold_data"}, {16'h0, sample_out}, {16'h0, d});
    chk({tag, "_hold_chan"}, {31'h0, channel_id}, {31'h0, ch});
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_sample_out", {16'h0, sample_out}, 32'h0);
    chk("rst_valid", {31'h0, sample_valid}, 32'h0);
    chk("rst_channel", {31'h0, channel_id}, 32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    send_word(1'b0, 32'hABCD, 16);
    chk("no_emit_first_word", cap_cnt, 0);
    send_word(1'b1, 32'h1234, 16);
    chk_emit("abcd_ch0", 0, 16'hABCD, 1'b0);
    chk("latency", {31'h0, (cap_lat[0] >= 50 && cap_lat[0] <= 70)}, 32'h1);
    send_word(1'b0, 32'h0000, 16);
    chk_emit("1234_ch1", 1, 16'h1234, 1'b1);
    send_word(1'b1, 32'hFFFF, 16);
    chk_emit("0000_ch0", 2, 16'h0000, 1'b0);
    send_word(1'b0, 32'h0001, 16);
    chk_emit("ffff_ch1", 3, 16'hFFFF, 1'b1);
    send_word(1'b1, 32'h0002, 16);
    chk_emit("b2b_0001", 4, 16'h0001, 1'b0);
    send_word(1'b0, 32'h0004, 16);
    chk_emit("b2b_0002", 5, 16'h0002, 1'b1);
    send_word(1'b1, 32'h0008, 16);
    chk_emit("b2b_0004", 6, 16'h0004, 1'b0);

    // Partial ch0 word, reset after its 8th bit while bclk is low
    bclk_cycle(1'b0, 1'b0);
    chk_emit("b2b_0008", 7, 16'h0008, 1'b1);
    for (int i = 7; i >= 0; i--) bclk_cycle(1'b0, i[0]);
    i2s_bclk = 1'b0;
    #50;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("midrst_sample_out", {16'h0, sample_out}, 32'h0);
    chk("midrst_valid", {31'h0, sample_valid}, 32'h0);
    chk("midrst_channel", {31'h0, channel_id}, 32'h0);
    sys_rst_n = 1'b1;
    #900;

    send_word(1'b1, 32'h5A5A, 16);
    chk("partial_discarded", cap_cnt, 8);
    chk("post_rst_hold", {16'h0, sample_out}, 32'h0);
    send_word(1'b0, 32'hF1234, 20);
    chk_emit("5a5a_ch1", 8, 16'h5A5A, 1'b1);
    send_word(1'b1, 32'hA5, 8);
    chk_emit("long_word", 9, 16'h1234, 1'b0);
    bclk_cycle(1'b0, 1'b0);
    bclk_cycle(1'b0, 1'b0);
    chk_emit("short_word", 10, 16'h00A5, 1'b1);

    // No bclk activity: outputs must hold
    #5000;
    chk("idle_count", cap_cnt, 11);
    chk("idle_hold", {16'h0, sample_out}, 32'h00A5);
    chk("valid_width", max_run, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_i2s_audio_receiver

`default_nettype wire

// File: doc/i2s_audio_receiver.md
Name: i2s_audio_receiver

Overview:
- Receives an I2S serial audio stream (external i2s_bclk, i2s_ws, i2s_sd), deserializes it MSB-first, and presents each completed word in the sys_clk domain.
- Each word is tagged with its channel (0 = left/ws low, 1 = right/ws high) and flagged by a one-cycle sample_valid pulse.
- Sits at the audio-sensor front end of the ASIC and feeds downstream buffering/NPU preprocessing.

Parameters:
- DATA_WIDTH, 16, bits per audio word and width of sample_out.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.

Ports:
- sys_clk  in  1  system clock; all logic runs on its rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- i2s_bclk  in  1  I2S bit clock, asynchronous to sys_clk; sys_clk must be at least 8x faster.
- i2s_ws  in  1  word select; 0 = channel 0, 1 = channel 1; changes just after a bclk falling edge.
- i2s_sd  in  1  serial data, MSB first; changes just after a bclk falling edge.
- sample_out  out  DATA_WIDTH  last completed word; holds until the next word completes.
- sample_valid  out  1  one-sys_clk pulse when sample_out/channel_id update.
- channel_id  out  1  channel of the word in sample_out.

Behaviour:
- Reset:
  - On sys_clk rising edge with sys_rst_n=0, clear all outputs and internal state.
  - sample_out=0, sample_valid=0, channel_id=0; shift_reg=0, bit_counter=0, ws_prev=0, armed=0, synchronizer flops=0.
  - A reset mid-word discards the partial word.
- Synchronization and edge detection:
  - i2s_bclk, i2s_ws and i2s_sd each pass through a SYNC_STAGES flop chain.
  - A bclk rising edge is the synced bclk being 1 while its previous-cycle copy is 0. The synced ws/sd values in that cycle are the sampled values.
- Per detected bclk rising edge, in priority order:
  1. armed=0 (first edge after reset): set ws_prev=ws, armed=1, then shift sd in normally as below. Never emit on this edge.
  2. ws != ws_prev (word boundary):
     - If bit_counter != 0: sample_out<=shift_reg (value before this edge's bit), channel_id<=ws_prev, sample_valid<=1 for exactly one sys_clk cycle.
     - Then shift_reg<=0, bit_counter<=0, ws_prev<=ws.
     - This edge's sd bit is the one-bit-delay slot and is discarded.
  3. Otherwise: shift_reg<={shift_reg[DATA_WIDTH-2:0], sd}; bit_counter increments, saturating at 31.
- Word length:
  - Words longer than DATA_WIDTH bits keep the last DATA_WIDTH bits captured.
  - Shorter words are right-aligned and zero-extended.
- Latency: sample_valid asserts SYNC_STAGES+1 sys_clk cycles after the bclk rising edge that follows the ws transition.
- sample_valid is 0 on every other cycle; back-to-back words produce one pulse each, at least one bclk period apart.
- If ws returns to its old level without any rising edge in between, no word boundary is seen.
- No bclk activity: outputs hold indefinitely.

Decomposition:
- Shared package i2s_pkg: DATA_WIDTH default (16), SYNC_STAGES default (2), bit_counter width constant (5).
- One sub-module, i2s_sync_ff: a parameterized 1-bit SYNC_STAGES flop synchronizer with synchronous active-low reset. Instantiate it three times (bclk, ws, sd).
- Edge detect, shift register and output registers live in the top module.

Test Plan:
- Common setup for all scenarios: sys_clk 50 MHz, bclk period 1953 ns. Drive ws at a bclk falling edge, then drive the 16 data bits 50 ns after each of the next 16 falling edges, then toggle ws at the following falling edge.
- Reset then 0xABCD on ch0 (ws low; no ws edge before data) -> one sample_valid pulse after the ws toggle; sample_out=0xABCD, channel_id=0.
- 0x1234 with ws=1, then ws->0 -> sample_out=0x1234, channel_id=1, single-cycle valid.
- 0x0000 on ch0, then 0xFFFF on ch1 -> sample_out=0x0000/ch0, then 0xFFFF/ch1. Checks that no stale bits leak between words.
- Back-to-back 0x0001/ch0, 0x0002/ch1, 0x0004/ch0, 0x0008/ch1 -> exactly four valid pulses, in order, with matching values and channels. sample_out holds between pulses.
- sys_rst_n low for 2 sys_clk cycles at bit 8 of a word, then a full 0x5A5A/ch1 -> the partial word is never emitted; output is 0x5A5A/ch1. All outputs read 0 during reset.
- 20-bit word 0xF1234 on ch0 -> sample_out=0x1234 (last 16 bits). 8-bit word 0xA5 -> sample_out=0x00A5.
